// File: rtl/uart_wrapper_pkg.sv
// Shared types and constants for the UART command/response wrapper.
// Optional inter-byte timeout is enabled by defining UART_WRAPPER_TIMEOUT_EN.
package uart_wrapper_pkg;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 50000;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        WAIT_LOW  = 2'd1,
        CMD_VALID = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_wrapper_byte_timer.sv
// Inter-byte timer: clearable cycle counter that flags the last allowed cycle.
// Only instantiated when UART_WRAPPER_TIMEOUT_EN is defined.
module byte_timer
    import uart_wrapper_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] count_r;

    // Cycle counter; holds at the last count rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (enable && (count_r != LAST_COUNT)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/uart_wrapper.sv
// Assembles two received UART bytes into a 16-bit command and transmits response bytes.
// Define UART_WRAPPER_TIMEOUT_EN to drop a lone high byte after TIMEOUT_CYC idle cycles.
module uart_wrapper
    import uart_wrapper_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    generate
        if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout
            $error("uart_wrapper: TIMEOUT_CYC must be within 2..65535");
        end
    endgenerate

    rx_state_t   rx_state_r;
    rx_state_t   rx_state_nxt_s;
    logic [15:0] cmd_r;
    logic [15:0] cmd_nxt_s;
    logic        cmd_rdy_r;
    logic        cmd_rdy_nxt_s;
    logic        clr_rx_rdy_r;
    logic        clr_rx_rdy_nxt_s;
    logic        rx_take_s;
    logic        timeout_s;

    tx_state_t   tx_state_r;
    tx_state_t   tx_state_nxt_s;
    logic [7:0]  tx_data_r;
    logic [7:0]  tx_data_nxt_s;
    logic        trmt_r;
    logic        trmt_nxt_s;
    logic        resp_sent_r;
    logic        resp_sent_nxt_s;

`ifdef UART_WRAPPER_TIMEOUT_EN
    byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_state_r != WAIT_LOW),
        .enable (rx_state_r == WAIT_LOW),
        .expire (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // RX next-state: a byte is taken only when the previous consume pulse has ended.
    always_comb begin
        rx_state_nxt_s   = rx_state_r;
        cmd_nxt_s        = cmd_r;
        cmd_rdy_nxt_s    = cmd_rdy_r;
        clr_rx_rdy_nxt_s = 1'b0;
        rx_take_s        = rx_rdy && !clr_rx_rdy_r;
        case (rx_state_r)
            WAIT_HIGH: begin
                if (rx_take_s) begin
                    cmd_nxt_s[15:8]  = rx_data;
                    clr_rx_rdy_nxt_s = 1'b1;
                    rx_state_nxt_s   = WAIT_LOW;
                end else begin
                    rx_state_nxt_s   = WAIT_HIGH;
                end
            end
            WAIT_LOW: begin
                // A byte arriving on the expiry cycle still completes the command.
                if (rx_take_s) begin
                    cmd_nxt_s[7:0]   = rx_data;
                    clr_rx_rdy_nxt_s = 1'b1;
                    cmd_rdy_nxt_s    = 1'b1;
                    rx_state_nxt_s   = CMD_VALID;
                end else if (timeout_s) begin
                    rx_state_nxt_s   = WAIT_HIGH;
                end else begin
                    rx_state_nxt_s   = WAIT_LOW;
                end
            end
            CMD_VALID: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_nxt_s  = 1'b0;
                    rx_state_nxt_s = WAIT_HIGH;
                end else begin
                    rx_state_nxt_s = CMD_VALID;
                end
            end
            default: begin
                cmd_rdy_nxt_s  = 1'b0;
                rx_state_nxt_s = WAIT_HIGH;
            end
        endcase
    end

    // RX state and registered RX outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_r   <= WAIT_HIGH;
            cmd_r        <= 16'h0000;
            cmd_rdy_r    <= 1'b0;
            clr_rx_rdy_r <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_nxt_s;
            cmd_r        <= cmd_nxt_s;
            cmd_rdy_r    <= cmd_rdy_nxt_s;
            clr_rx_rdy_r <= clr_rx_rdy_nxt_s;
        end
    end

    // TX next-state: one byte in flight, further requests dropped until done.
    always_comb begin
        tx_state_nxt_s  = tx_state_r;
        tx_data_nxt_s   = tx_data_r;
        trmt_nxt_s      = 1'b0;
        resp_sent_nxt_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_nxt_s  = resp;
                    trmt_nxt_s     = 1'b1;
                    tx_state_nxt_s = TX_BUSY;
                end else begin
                    tx_state_nxt_s = TX_IDLE;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_nxt_s = 1'b1;
                    tx_state_nxt_s  = TX_IDLE;
                end else begin
                    tx_state_nxt_s  = TX_BUSY;
                end
            end
            default: begin
                tx_state_nxt_s = TX_IDLE;
            end
        endcase
    end

    // TX state and registered TX outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_r  <= TX_IDLE;
            tx_data_r   <= 8'h00;
            trmt_r      <= 1'b0;
            resp_sent_r <= 1'b0;
        end else begin
            tx_state_r  <= tx_state_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            trmt_r      <= trmt_nxt_s;
            resp_sent_r <= resp_sent_nxt_s;
        end
    end

    assign cmd        = cmd_r;
    assign cmd_rdy    = cmd_rdy_r;
    assign clr_rx_rdy = clr_rx_rdy_r;
    assign tx_data    = tx_data_r;
    assign trmt       = trmt_r;
    assign resp_sent  = resp_sent_r;

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed bench for uart_wrapper: a cycle-by-cycle vector table plus timeout sequences.
// Timeout expectations follow UART_WRAPPER_TIMEOUT_EN as defined for the build.
module tb_uart_wrapper;

    logic        clk;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    int n_checks = 0;
    int n_fail   = 0;

    uart_wrapper #(.TIMEOUT_CYC(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rxr;
        logic [7:0]  rxd;
        logic        clrc;
        logic        sr;
        logic [7:0]  rsp;
        logic        txd;
        logic        e_clr;
        logic        e_trmt;
        logic [7:0]  e_txdata;
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic        e_sent;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic rxr, input logic [7:0] rxd,
                                input logic clrc, input logic sr, input logic [7:0] rsp,
                                input logic txd, input logic e_clr, input logic e_trmt,
                                input logic [7:0] e_txdata, input logic [15:0] e_cmd,
                                input logic e_rdy, input logic e_sent);
        vec_t v;
        v.rst = rst; v.rxr = rxr; v.rxd = rxd; v.clrc = clrc; v.sr = sr; v.rsp = rsp;
        v.txd = txd; v.e_clr = e_clr; v.e_trmt = e_trmt; v.e_txdata = e_txdata;
        v.e_cmd = e_cmd; v.e_rdy = e_rdy; v.e_sent = e_sent;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Present a byte like a UART receiver: hold rx_rdy until clr_rx_rdy is seen.
    task automatic send_byte(input logic [7:0] b, input string name);
        logic got;
        got = 1'b0;
        rx_rdy  = 1'b1;
        rx_data = b;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (clr_rx_rdy) begin
                got = 1'b1;
                break;
            end
        end
        rx_rdy = 1'b0;
        check({name, " consumed"}, {15'd0, got}, 16'd1);
    endtask

    task automatic release_cmd(input string name);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check({name, " cmd_rdy cleared"}, {15'd0, cmd_rdy}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
        clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;

        //                rst  rxr   rxd   clrc  sr    rsp   txd   clr   trmt  txdat cmd      rdy   sent
        vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h47,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,16'h4700,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h47,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h4700,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h4700,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h0A,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,16'h470A,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h0A,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h470A,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'hFF,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h470A,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'hFF,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h470A,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'hFF,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h470A,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'hFF,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,16'hFF0A,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'hFF,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'hFF0A,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'hFF0A,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'hFF0A,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h3C,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,16'hFF3C,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'hFF3C,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'hFF3C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,16'hFF3C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b1,8'hA5,1'b0, 1'b0,1'b1,8'hA5,16'hFF3C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b1,8'hEE,1'b0, 1'b0,1'b0,8'hA5,16'hFF3C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'hA5,16'hFF3C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'hA5,16'hFF3C,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b1,8'h3C,1'b0, 1'b0,1'b1,8'h3C,16'hFF3C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h3C,16'hFF3C,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h3C,16'hFF3C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h40,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h3C,16'h403C,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b1,8'h5A,1'b0, 1'b0,1'b1,8'h5A,16'h403C,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h01,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,16'h0100,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h0100,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'h02,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,16'h0102,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h0102,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,16'h0102,1'b0,1'b0));

        foreach (vecs[i]) begin
            rst_n       = vecs[i].rst;
            rx_rdy      = vecs[i].rxr;
            rx_data     = vecs[i].rxd;
            clr_cmd_rdy = vecs[i].clrc;
            send_resp   = vecs[i].sr;
            resp        = vecs[i].rsp;
            tx_done     = vecs[i].txd;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d clr_rx_rdy", i), {15'd0, clr_rx_rdy}, {15'd0, vecs[i].e_clr});
            check($sformatf("v%0d trmt", i),       {15'd0, trmt},       {15'd0, vecs[i].e_trmt});
            check($sformatf("v%0d tx_data", i),    {8'd0, tx_data},     {8'd0, vecs[i].e_txdata});
            check($sformatf("v%0d cmd", i),        cmd,                 vecs[i].e_cmd);
            check($sformatf("v%0d cmd_rdy", i),    {15'd0, cmd_rdy},    {15'd0, vecs[i].e_rdy});
            check($sformatf("v%0d resp_sent", i),  {15'd0, resp_sent},  {15'd0, vecs[i].e_sent});
        end
        rst_n = 1'b1; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;

        // Lone high byte followed by a long gap.
        send_byte(8'h81, "gap hi");
        tick(110);
        check("gap cmd_rdy idle", {15'd0, cmd_rdy}, 16'd0);
`ifdef UART_WRAPPER_TIMEOUT_EN
        send_byte(8'h02, "gap b2");
        send_byte(8'h03, "gap b3");
        check("gap cmd", cmd, 16'h0203);
`else
        send_byte(8'h02, "gap b2");
        check("gap cmd", cmd, 16'h8102);
`endif
        check("gap cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
        release_cmd("gap");

        // Exactly TIMEOUT_CYC cycles in WAIT_LOW without a byte.
        send_byte(8'h33, "exp hi");
        tick(100);
        check("exp cmd_rdy idle", {15'd0, cmd_rdy}, 16'd0);
`ifdef UART_WRAPPER_TIMEOUT_EN
        send_byte(8'h44, "exp b2");
        send_byte(8'h55, "exp b3");
        check("exp cmd", cmd, 16'h4455);
`else
        send_byte(8'h44, "exp b2");
        check("exp cmd", cmd, 16'h3344);
`endif
        check("exp cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
        release_cmd("exp");

        // Low byte lands on the expiry cycle itself.
        send_byte(8'h11, "edge hi");
        tick(99);
        send_byte(8'h22, "edge lo");
        check("edge cmd", cmd, 16'h1122);
        check("edge cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
        release_cmd("edge");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
